// File: rtl/admm_fixed_pkg.sv
// Shared fixed-point helpers for the ADMM-LP projection path: ceil-log2, derived widths
// and array pack/unpack macros used by the cut checker and the facet-projection stage.
`ifndef ADMM_FIXED_PKG_MACROS
`define ADMM_FIXED_PKG_MACROS
`define ADMM_UNPACK_ARRAY(dst, src, W, N) for (int unpack_i = 0; unpack_i < (N); unpack_i++) dst[unpack_i] = src[(W)*unpack_i +: (W)];
`define ADMM_PACK_ARRAY(dst, src, W, N) for (int pack_i = 0; pack_i < (N); pack_i++) dst[(W)*pack_i +: (W)] = src[pack_i];
`endif

package admm_fixed_pkg;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v * 2;
            r = r + 1;
        end
        return r;
    endfunction

    // Result width of a sum of n signed elements minus a threshold up to (n-1)<<frac.
    function automatic int sum_width(input int data_width, input int n);
        return data_width + 2 + clog2(n);
    endfunction

    function automatic int popcount_width(input int n);
        return clog2(n + 1);
    endfunction

    // Number of live nodes remaining after `lvl` pairwise-add levels.
    function automatic int level_count(input int n, input int lvl);
        return (n + (1 << lvl) - 1) >> lvl;
    endfunction

endpackage

// File: rtl/signed_adder_tree.sv
// Pipelined signed adder tree: ceil(log2(BLOCKLENGTH)) register levels, odd leftovers pass through.
module signed_adder_tree
    import admm_fixed_pkg::*;
#(
    parameter int BLOCKLENGTH = 1,
    parameter int IN_WIDTH    = 9
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          enable,
    input  logic [IN_WIDTH*BLOCKLENGTH-1:0]               data_in,
    output logic signed [IN_WIDTH+clog2(BLOCKLENGTH)-1:0] sum_out
);

    localparam int LEVELS    = clog2(BLOCKLENGTH);
    localparam int OUT_WIDTH = IN_WIDTH + LEVELS;
    localparam int SIZE      = BLOCKLENGTH + 1;

    // Every level carries the full output width; the spare slot keeps pair indexing in range.
    for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
        localparam int CNT = level_count(BLOCKLENGTH, l);
        logic signed [OUT_WIDTH-1:0] stage [0:SIZE-1];

        if (l == 0) begin : g_leaf
            always_comb begin
                for (int j = 0; j < BLOCKLENGTH; j++)
                    stage[j] = OUT_WIDTH'($signed(data_in[IN_WIDTH*j +: IN_WIDTH]));
                stage[BLOCKLENGTH] = '0;
            end
        end else begin : g_sum
            localparam int PREV = level_count(BLOCKLENGTH, l - 1);
            always_ff @(posedge clk) begin
                if (reset) begin
                    stage <= '{default: '0};
                end else if (enable) begin
                    for (int j = 0; j < SIZE; j++)
                        stage[j] <= '0;
                    for (int j = 0; j < CNT; j++)
                        stage[j] <= (2*j + 1 < PREV) ? g_lvl[l-1].stage[2*j] + g_lvl[l-1].stage[2*j+1]
                                                     : g_lvl[l-1].stage[2*j];
                end
            end
        end
    end

    if (LEVELS == 0) begin : g_no_regs
        logic unused_ctrl;
        assign unused_ctrl = &{1'b0, clk, reset, enable};
    end

    assign sum_out = g_lvl[LEVELS].stage[0];

endmodule

// File: rtl/cut_violation_check.sv
// Facet-inequality check for one check node: excess = sum(f?v:-v) - ((|f|-1)<<frac), violated = excess>0.
// Optional build macro CUT_CHECK_STATS_EN adds a saturating viol_count output.
module cut_violation_check
    import admm_fixed_pkg::*;
#(
    parameter int TAG_WIDTH         = 32,
    parameter int BLOCKLENGTH       = 1,
    parameter int DATA_WIDTH        = 8,
    parameter int IN_FRACTION_WIDTH = 6
) (
    input  logic                                                 clk,
    input  logic                                                 reset,
    input  logic                                                 ready_in,
    input  logic                                                 valid_in,
    input  logic [TAG_WIDTH-1:0]                                 tag_in,
    input  logic [DATA_WIDTH*BLOCKLENGTH-1:0]                    data_in,
    input  logic [0:BLOCKLENGTH-1]                               f_in,
    output logic                                                 busy,
    output logic                                                 ready_out,
    output logic                                                 valid_out,
    output logic [TAG_WIDTH-1:0]                                 tag_out,
    output logic [0:BLOCKLENGTH-1]                               f_out,
    output logic signed [sum_width(DATA_WIDTH, BLOCKLENGTH)-1:0] excess_out,
`ifdef CUT_CHECK_STATS_EN
    output logic [15:0]                                          viol_count,
`endif
    output logic                                                 violated
);

    localparam int LEVELS     = clog2(BLOCKLENGTH);
    localparam int SUM_WIDTH  = sum_width(DATA_WIDTH, BLOCKLENGTH);
    localparam int T_WIDTH    = DATA_WIDTH + 1;
    localparam int TREE_WIDTH = T_WIDTH + LEVELS;
    localparam int PC_WIDTH   = popcount_width(BLOCKLENGTH);

    logic                                enable;
    logic                                s0_valid;
    logic [TAG_WIDTH-1:0]                s0_tag;
    logic [DATA_WIDTH*BLOCKLENGTH-1:0]   s0_data;
    logic [0:BLOCKLENGTH-1]              s0_f;
    logic signed [DATA_WIDTH-1:0]        v_elem [0:BLOCKLENGTH-1];
    logic signed [T_WIDTH-1:0]           t_elem [0:BLOCKLENGTH-1];
    logic [T_WIDTH*BLOCKLENGTH-1:0]      t_next;
    logic [T_WIDTH*BLOCKLENGTH-1:0]      t_flat;
    logic [PC_WIDTH-1:0]                 pc_next;
    logic [LEVELS:0]                     valid_d;
    logic [TAG_WIDTH-1:0]                tag_d [0:LEVELS];
    logic [0:BLOCKLENGTH-1]              f_d   [0:LEVELS];
    logic [PC_WIDTH-1:0]                 pc_d  [0:LEVELS];
    logic signed [TREE_WIDTH-1:0]        tree_sum;
    logic signed [SUM_WIDTH-1:0]         threshold;
    logic signed [SUM_WIDTH-1:0]         excess_next;

    assign enable    = ready_in | ~valid_out;
    assign ready_out = enable;
    assign busy      = s0_valid | (|valid_d) | valid_out;

    // Sign-extend by one bit first so negating the most negative element cannot wrap.
    always_comb begin
        t_next  = '0;
        pc_next = '0;
        `ADMM_UNPACK_ARRAY(v_elem, s0_data, DATA_WIDTH, BLOCKLENGTH)
        for (int i = 0; i < BLOCKLENGTH; i++) begin
            t_elem[i] = s0_f[i] ? T_WIDTH'(v_elem[i]) : -(T_WIDTH'(v_elem[i]));
            pc_next   = pc_next + PC_WIDTH'(s0_f[i]);
        end
        `ADMM_PACK_ARRAY(t_next, t_elem, T_WIDTH, BLOCKLENGTH)
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s0_valid   <= 1'b0;
            s0_tag     <= '0;
            s0_data    <= '0;
            s0_f       <= '0;
            valid_d[0] <= 1'b0;
            tag_d[0]   <= '0;
            f_d[0]     <= '0;
            pc_d[0]    <= '0;
            t_flat     <= '0;
        end else if (enable) begin
            s0_valid   <= valid_in;
            s0_tag     <= tag_in;
            s0_data    <= data_in;
            s0_f       <= f_in;
            valid_d[0] <= s0_valid;
            tag_d[0]   <= s0_tag;
            f_d[0]     <= s0_f;
            pc_d[0]    <= pc_next;
            t_flat     <= t_next;
        end
    end

    signed_adder_tree #(
        .BLOCKLENGTH(BLOCKLENGTH),
        .IN_WIDTH   (T_WIDTH)
    ) u_tree (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .data_in(t_flat),
        .sum_out(tree_sum)
    );

    // Side-band delay alongside the tree levels; empty when BLOCKLENGTH is 1.
    always_ff @(posedge clk) begin
        for (int k = 1; k <= LEVELS; k++) begin
            if (reset) begin
                valid_d[k] <= 1'b0;
                tag_d[k]   <= '0;
                f_d[k]     <= '0;
                pc_d[k]    <= '0;
            end else if (enable) begin
                valid_d[k] <= valid_d[k-1];
                tag_d[k]   <= tag_d[k-1];
                f_d[k]     <= f_d[k-1];
                pc_d[k]    <= pc_d[k-1];
            end
        end
    end

    always_comb begin
        threshold   = (SUM_WIDTH'(pc_d[LEVELS]) - SUM_WIDTH'(1)) << IN_FRACTION_WIDTH;
        excess_next = SUM_WIDTH'(tree_sum) - threshold;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_out  <= 1'b0;
            tag_out    <= '0;
            f_out      <= '0;
            excess_out <= '0;
            violated   <= 1'b0;
        end else if (enable) begin
            valid_out  <= valid_d[LEVELS];
            tag_out    <= tag_d[LEVELS];
            f_out      <= f_d[LEVELS];
            excess_out <= excess_next;
            violated   <= ~excess_next[SUM_WIDTH-1] & (excess_next != '0);
        end
    end

`ifdef CUT_CHECK_STATS_EN
    always_ff @(posedge clk) begin
        if (reset)
            viol_count <= '0;
        else if (valid_out & ready_in & violated & (viol_count != 16'hFFFF))
            viol_count <= viol_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_cut_violation_check.sv
// Randomized scoreboard bench for cut_violation_check at BLOCKLENGTH=4, DATA_WIDTH=8, 1.0=64.
module tb_cut_violation_check;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int TW = 32;
    localparam int SW = 12;

    logic                 clk;
    logic                 reset;
    logic                 ready_in;
    logic                 valid_in;
    logic [TW-1:0]        tag_in;
    logic [DW*N-1:0]      data_in;
    logic [0:N-1]         f_in;
    logic                 busy;
    logic                 ready_out;
    logic                 valid_out;
    logic [TW-1:0]        tag_out;
    logic [0:N-1]         f_out;
    logic signed [SW-1:0] excess_out;
    logic                 violated;
`ifdef CUT_CHECK_STATS_EN
    logic [15:0]          viol_count;
`endif

    typedef struct {
        logic [TW-1:0] tag;
        logic [0:N-1]  f;
        int            excess;
    } exp_t;

    exp_t sb_q[$];
    int   check_count = 0;
    int   fail_count  = 0;
    int   model_viol  = 0;
    bit   rand_ready  = 0;
    bit   ready_force = 0;

    cut_violation_check #(
        .TAG_WIDTH(TW), .BLOCKLENGTH(N), .DATA_WIDTH(DW), .IN_FRACTION_WIDTH(6)
    ) dut (
        .clk(clk), .reset(reset), .ready_in(ready_in), .valid_in(valid_in),
        .tag_in(tag_in), .data_in(data_in), .f_in(f_in), .busy(busy),
        .ready_out(ready_out), .valid_out(valid_out), .tag_out(tag_out),
        .f_out(f_out), .excess_out(excess_out),
`ifdef CUT_CHECK_STATS_EN
        .viol_count(viol_count),
`endif
        .violated(violated)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Facet inequality from first principles: signed sum over the cut minus (|f|-1) * 1.0.
    function automatic int model_excess(logic [DW*N-1:0] d, logic [0:N-1] f);
        int s = 0;
        int w = 0;
        logic signed [DW-1:0] e;
        for (int i = 0; i < N; i++) begin
            e = d[DW*i +: DW];
            if (f[i]) begin s += e; w++; end
            else s -= e;
        end
        return s - (w - 1) * 64;
    endfunction

    task automatic checkValue(input string name, input longint actual, input longint expected);
        check_count++;
        if (actual != expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        checkValue("excess", longint'(excess_out), longint'(e.excess));
        checkValue("violated", longint'(violated), (e.excess > 0) ? 1 : 0);
        checkValue("tag_out", longint'(tag_out), longint'(e.tag));
        checkValue("f_out", longint'(f_out), longint'(e.f));
    endtask

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic applyStimulus(input logic [TW-1:0] tag, input logic [DW*N-1:0] data, input logic [0:N-1] f);
        exp_t e;
        valid_in = 1'b1;
        tag_in   = tag;
        data_in  = data;
        f_in     = f;
        #1;
        for (int c = 0; c < 200; c++) begin
            if (ready_out) begin
                e.tag = tag; e.f = f; e.excess = model_excess(data, f);
                sb_q.push_back(e);
                @(negedge clk);
                valid_in = 1'b0;
                return;
            end
            @(negedge clk);
            #1;
        end
        checkValue("accept_timeout", 0, 1);
        valid_in = 1'b0;
    endtask

    task automatic drain();
        int c = 0;
        while ((sb_q.size() != 0 || busy) && c < 300) begin
            @(negedge clk);
            c++;
        end
        checkValue("drain_remaining", longint'(sb_q.size()), 0);
    endtask

    initial begin : ready_driver
        forever begin
            @(negedge clk);
            ready_in = rand_ready ? ($urandom_range(0, 9) < 7) : ready_force;
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!reset && valid_out) begin
                if (sb_q.size() == 0) begin
                    checkValue("unexpected_output", 1, 0);
                end else begin
                    e = sb_q[0];
                    checkOutput(e);
                    if (ready_in) begin
                        void'(sb_q.pop_front());
                        if (e.excess > 0) model_viol++;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin : main
        int lat;
        int run;
        reset = 1'b1; valid_in = 1'b0; ready_in = 1'b0; tag_in = '0; data_in = '0; f_in = '0;
        repeat (3) @(negedge clk);
        checkValue("reset_valid_out", longint'(valid_out), 0);
        checkValue("reset_busy", longint'(busy), 0);
        checkValue("reset_excess", longint'(excess_out), 0);
        checkValue("reset_ready_out", longint'(ready_out), 1);
        reset = 1'b0;
        ready_force = 1'b1;
        @(negedge clk);

        $display("[TB] directed facet cases");
        applyStimulus(32'd5, {8'd0, 8'd64, 8'd64, 8'd64}, 4'b1110);
        lat = 1;
        while (!valid_out && lat < 20) begin @(negedge clk); lat++; end
        checkValue("latency", lat, 5);
        applyStimulus(32'd6, {8'd0, 8'd0, 8'd64, 8'd64}, 4'b1110);
        applyStimulus(32'd7, {8'd32, 8'd32, 8'd32, 8'd32}, 4'b1000);
        applyStimulus(32'd8, 32'd0, 4'b0000);
        applyStimulus(32'd9, {8'h80, 8'h80, 8'h80, 8'h80}, 4'b0000);
        applyStimulus(32'd10, {8'h7F, 8'h7F, 8'h7F, 8'h7F}, 4'b1111);
        drain();

        $display("[TB] back-to-back burst");
        run = 0;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    applyStimulus(32'h100 + i, $urandom, 4'($urandom));
            end
            begin
                int w = 0;
                while (!valid_out && w < 40) begin @(negedge clk); w++; end
                while (valid_out && run < 20) begin run++; @(negedge clk); end
            end
        join
        checkValue("b2b_run", run, 8);
        drain();

        $display("[TB] stall with full pipeline");
        ready_force = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++)
            applyStimulus(32'h200 + i, $urandom, 4'($urandom));
        for (int i = 0; i < 10; i++) begin
            #1;
            checkValue("stall_ready_out", longint'(ready_out), 0);
            @(negedge clk);
        end
        checkValue("stall_queue_depth", longint'(sb_q.size()), 5);
        ready_force = 1'b1;
        drain();

        $display("[TB] reset with beats in flight");
        for (int i = 0; i < 3; i++)
            applyStimulus(32'h300 + i, $urandom, 4'($urandom));
        reset = 1'b1;
        @(negedge clk);
        checkValue("flush_busy", longint'(busy), 0);
        checkValue("flush_valid_out", longint'(valid_out), 0);
        checkValue("flush_excess", longint'(excess_out), 0);
        sb_q.delete();
        model_viol = 0;
`ifdef CUT_CHECK_STATS_EN
        checkValue("flush_viol_count", longint'(viol_count), 0);
`endif
        reset = 1'b0;
        @(negedge clk);
        #1;
        checkValue("post_reset_ready_out", longint'(ready_out), 1);
        @(negedge clk);

        $display("[TB] randomized traffic");
        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            applyStimulus($urandom, $urandom, 4'($urandom));
        end
        rand_ready = 1'b0;
        ready_force = 1'b1;
        drain();
`ifdef CUT_CHECK_STATS_EN
        checkValue("viol_count", longint'(viol_count), longint'(model_viol));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
        $finish;
    end

endmodule
